// File: rtl/siso_shift_sched_if.sv
// Requester-side handshake bundle for the SISO shift scheduler.
// master: requester (drives valid/data); slave: scheduler (drives ready).
interface siso_shift_sched_if #(
    parameter int WIDTH = 4
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;

    modport master (
        output req0_valid,
        output req0_data,
        input  req0_ready,
        output req1_valid,
        output req1_data,
        input  req1_ready
    );

    modport slave (
        input  req0_valid,
        input  req0_data,
        output req0_ready,
        input  req1_valid,
        input  req1_data,
        output req1_ready
    );
endinterface

// File: rtl/siso_shift_sched.sv
// Two-requester round-robin scheduler feeding a WIDTH-bit SISO right-shift
// register. Accepts one parallel word, then serializes it LSB first.
//
// Ports:
//   clk, rst     clock, async active-high reset
//   bus (slave)  req0/req1 valid, data, ready handshakes
//   ser_out      serial bit for the shift register input
//   shift_en     downstream register shifts on edges where this is high
//   busy         frame in progress (SHIFT or GAP)
//   grant_id     owner of the current or most recent frame
//   frame_done   one-cycle pulse after the last shift
module siso_shift_sched #(
    parameter int WIDTH = 4,
    parameter int GAP   = 1
) (
    input  logic              clk,
    input  logic              rst,
    siso_shift_sched_if.slave bus,
    output logic              ser_out,
    output logic              shift_en,
    output logic              busy,
    output logic              grant_id,
    output logic              frame_done
);

    localparam int CW = $clog2(WIDTH);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             ser_q, ser_d;
    logic             sen_q, sen_d;
    logic             done_q, done_d;
    logic             gid_q, gid_d;
    // ptr_q = 1 means requester 1 has priority in a tie
    logic             ptr_q, ptr_d;

    logic             win0, win1;
    logic             acc0, acc1;
    logic [WIDTH-1:0] cap;

    always_comb begin
        win0 = bus.req0_valid && (!bus.req1_valid || !ptr_q);
        win1 = bus.req1_valid && (!bus.req0_valid || ptr_q);
    end

    // Ready only in IDLE and never while reset is held.
    assign bus.req0_ready = (state_q == ST_IDLE) && !rst && win0;
    assign bus.req1_ready = (state_q == ST_IDLE) && !rst && win1;

    assign acc0 = bus.req0_valid && bus.req0_ready;
    assign acc1 = bus.req1_valid && bus.req1_ready;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        shadow_d  = shadow_q;
        ser_d     = 1'b0;
        sen_d     = 1'b0;
        done_d    = 1'b0;
        gid_d     = gid_q;
        ptr_d     = ptr_q;
        cap       = '0;

        unique case (state_q)
            ST_IDLE: begin
                unique case (1'b1)
                    acc0: begin
                        cap   = bus.req0_data;
                        gid_d = 1'b0;
                    end
                    acc1: begin
                        cap   = bus.req1_data;
                        gid_d = 1'b1;
                    end
                    default: ;
                endcase
                if (acc0 || acc1) begin
                    // Bit 0 goes out in the first SHIFT cycle; the
                    // remaining bits wait in the shadow register.
                    ptr_d     = acc0;
                    bit_cnt_d = '0;
                    ser_d     = cap[0];
                    sen_d     = 1'b1;
                    shadow_d  = cap >> 1;
                    state_d   = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (bit_cnt_q == BIT_LAST) begin
                    done_d    = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = (GAP == 0) ? ST_IDLE : ST_GAP;
                end else begin
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    ser_d     = shadow_q[0];
                    sen_d     = 1'b1;
                    shadow_d  = shadow_q >> 1;
                end
            end

            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            shadow_q  <= '0;
            ser_q     <= 1'b0;
            sen_q     <= 1'b0;
            done_q    <= 1'b0;
            gid_q     <= 1'b0;
            ptr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            shadow_q  <= shadow_d;
            ser_q     <= ser_d;
            sen_q     <= sen_d;
            done_q    <= done_d;
            gid_q     <= gid_d;
            ptr_q     <= ptr_d;
        end
    end

    assign ser_out    = ser_q;
    assign shift_en   = sen_q;
    assign frame_done = done_q;
    assign grant_id   = gid_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_siso_shift_sched.sv
// Bench for siso_shift_sched: three instances (GAP = 1, 0, 3) against a
// frame-phase model plus directed literal expectations.
module tb_siso_shift_sched;

    localparam int W   = 4;
    localparam int BIG = 1000;

    logic clk;
    logic rst;

    logic [2:0]        v0, v1;
    logic [2:0][W-1:0] d0, d1;

    wire [2:0] r0, r1, ser, sen, bsy, gid, done;

    logic [2:0][W-1:0] qd = '0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int         mk[3] = '{BIG, BIG, BIG};
    logic [W-1:0] mw[3] = '{default: '0};
    logic       mg[3] = '{default: 1'b0};
    logic       mp[3] = '{default: 1'b0};

    generate
        for (genvar g = 0; g < 3; g++) begin : gi
            localparam int GP = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
            siso_shift_sched_if #(.WIDTH(W)) bus ();
            assign bus.req0_valid = v0[g];
            assign bus.req0_data  = d0[g];
            assign bus.req1_valid = v1[g];
            assign bus.req1_data  = d1[g];
            assign r0[g] = bus.req0_ready;
            assign r1[g] = bus.req1_ready;
            siso_shift_sched #(.WIDTH(W), .GAP(GP)) dut (
                .clk        (clk),
                .rst        (rst),
                .bus        (bus.slave),
                .ser_out    (ser[g]),
                .shift_en   (sen[g]),
                .busy       (bsy[g]),
                .grant_id   (gid[g]),
                .frame_done (done[g])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream right-shift register, one per instance.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++)
            if (sen[i]) qd[i] <= {ser[i], qd[i][W-1:1]};
    end

    function automatic int gapv(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 0 : 3);
    endfunction

    // Model: mk = cycles since acceptance (1 = first shift cycle).
    function automatic logic m_idle(input int i);
        return mk[i] > W + gapv(i);
    endfunction

    function automatic logic er0(input int i);
        return !rst && m_idle(i) && v0[i] && (!v1[i] || !mp[i]);
    endfunction

    function automatic logic er1(input int i);
        return !rst && m_idle(i) && v1[i] && (!v0[i] || mp[i]);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                mk[i] <= BIG;
                mp[i] <= 1'b0;
                mg[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (er0(i)) begin
                    mk[i] <= 1;
                    mw[i] <= d0[i];
                    mg[i] <= 1'b0;
                    mp[i] <= 1'b1;
                end else if (er1(i)) begin
                    mk[i] <= 1;
                    mw[i] <= d1[i];
                    mg[i] <= 1'b1;
                    mp[i] <= 1'b0;
                end else if (mk[i] < BIG) begin
                    mk[i] <= mk[i] + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        int k, g;
        logic eser;
        logic [6:0] e, a;
        for (int i = 0; i < 3; i++) begin
            k = mk[i];
            g = gapv(i);
            eser = 1'b0;
            if (k >= 1 && k <= W) eser = mw[i][k-1];
            e = {er0(i), er1(i), (k >= 1 && k <= W), eser,
                 (k >= 1 && k <= W + g), mg[i], (k == W + 1)};
            a = {r0[i], r1[i], sen[i], ser[i], bsy[i], gid[i], done[i]};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle_cmp inst=%0d cyc=%0d act=%b exp=%b (r0 r1 sen ser busy gid done)",
                         i, cyc, a, e);
            end
            if (k == W + 1) begin
                checks++;
                if (qd[i] !== mw[i]) begin
                    errors++;
                    $display("FAIL q_at_done inst=%0d act=%h exp=%h", i, qd[i], mw[i]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic accept(input int i, input bit which);
        bit ok;
        ok = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if ((which ? r1[i] : r0[i]) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk($sformatf("accept_i%0d_r%0d", i, which), {31'd0, ok}, 32'd1);
        if (ok) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic run_frame(input int i, output logic [W-1:0] bits,
                             output int nb, output logic [W-1:0] qv,
                             output logic g, output int dc);
        bit ok;
        ok   = 1'b0;
        bits = '0;
        nb   = 0;
        qv   = '0;
        g    = 1'b0;
        dc   = 0;
        repeat (40) begin
            @(negedge clk);
            if (sen[i]) begin
                if (nb < W) bits[nb] = ser[i];
                nb++;
            end
            if (done[i]) begin
                qv = qd[i];
                g  = gid[i];
                dc = cyc;
                ok = 1'b1;
                break;
            end
        end
        chk($sformatf("frame_done_seen_i%0d", i), {31'd0, ok}, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] bits, qv, q1, q2;
        logic         g, g1, g2;
        int           nb, dc, dc1, dc2, n, wc, bc, rc, dcnt;
        bit           seen;

        rst = 1'b0;
        v0  = '0;
        v1  = '0;
        d0  = '0;
        d1  = '0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        @(negedge clk);
        chk("rst_busy", {31'd0, bsy[0]}, 32'd0);
        chk("rst_shift_en", {31'd0, sen[0]}, 32'd0);
        chk("rst_ser", {31'd0, ser[0]}, 32'd0);
        chk("rst_done", {29'd0, done}, 32'd0);
        chk("rst_gid", {29'd0, gid}, 32'd0);

        // Single frame, req0 = 1011
        #2;
        v0[0] = 1'b1;
        d0[0] = 4'b1011;
        accept(0, 1'b0);
        v0[0] = 1'b0;
        run_frame(0, bits, nb, qv, g, dc);
        chk("t1_ser_bits", {28'd0, bits}, 32'hB);
        chk("t1_nshift", nb, 4);
        chk("t1_q", {28'd0, qv}, 32'hB);
        chk("t1_gid", {31'd0, g}, 32'd0);

        // Contention from reset: A / 5 alternate starting with req0
        do_reset();
        v0[0] = 1'b1;
        v1[0] = 1'b1;
        d0[0] = 4'hA;
        d1[0] = 4'h5;
        for (int f = 0; f < 4; f++) begin
            run_frame(0, bits, nb, qv, g, dc);
            chk($sformatf("t2_gid_f%0d", f), {31'd0, g}, f % 2);
            chk($sformatf("t2_q_f%0d", f), {28'd0, qv},
                (f % 2 == 1) ? 32'h5 : 32'hA);
        end
        #2;
        v0[0] = 1'b0;
        v1[0] = 1'b0;

        // Mid-frame reset: req0 granted last, then abort 4'hF frame
        v0[0] = 1'b1;
        d0[0] = 4'h6;
        accept(0, 1'b0);
        v0[0] = 1'b0;
        run_frame(0, bits, nb, qv, g, dc);
        chk("t3_pre_gid", {31'd0, g}, 32'd0);
        v0[0] = 1'b1;
        d0[0] = 4'hF;
        accept(0, 1'b0);
        v0[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #3;
        chk("t3_shift_active", {31'd0, sen[0]}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t3_async_shift_en", {31'd0, sen[0]}, 32'd0);
        chk("t3_async_busy", {31'd0, bsy[0]}, 32'd0);
        dcnt = 0;
        @(negedge clk);
        if (done[0]) dcnt++;
        #2 rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done[0]) dcnt++;
        end
        chk("t3_no_done", dcnt, 0);
        #2;
        v0[0] = 1'b1;
        v1[0] = 1'b1;
        d0[0] = 4'h9;
        d1[0] = 4'h6;
        accept(0, 1'b0);
        v0[0] = 1'b0;
        v1[0] = 1'b0;
        run_frame(0, bits, nb, qv, g, dc);
        chk("t3_post_gid", {31'd0, g}, 32'd0);
        chk("t3_post_q", {28'd0, qv}, 32'h9);

        // Valid withdrawn while busy: req1 never accepted
        #2;
        v0[0] = 1'b1;
        d0[0] = 4'h2;
        accept(0, 1'b0);
        v0[0] = 1'b0;
        rc   = 0;
        dcnt = 0;
        for (int j = 0; j < 15; j++) begin
            @(negedge clk);
            if (r1[0]) rc++;
            if (done[0]) dcnt++;
            if (j == 0) begin
                #2;
                v1[0] = 1'b1;
                d1[0] = 4'h7;
            end
            if (j == 1) begin
                #2;
                v1[0] = 1'b0;
            end
        end
        chk("t4_r1_never", rc, 0);
        chk("t4_one_frame", dcnt, 1);

        // GAP = 0 back-to-back on req1: 3 then C
        #2;
        v1[1] = 1'b1;
        d1[1] = 4'h3;
        accept(1, 1'b1);
        d1[1] = 4'hC;
        run_frame(1, bits, nb, q1, g1, dc1);
        run_frame(1, bits, nb, q2, g2, dc2);
        #2;
        v1[1] = 1'b0;
        chk("t5_q1", {28'd0, q1}, 32'h3);
        chk("t5_q2", {28'd0, q2}, 32'hC);
        chk("t5_gid1", {31'd0, g1}, 32'd1);
        chk("t5_gid2", {31'd0, g2}, 32'd1);
        chk("t5_done_spacing", dc2 - dc1, W + 1);

        // GAP = 3: request raised in the last SHIFT cycle
        v0[2] = 1'b1;
        d0[2] = 4'h5;
        accept(2, 1'b0);
        v0[2] = 1'b0;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (sen[2]) n++;
            if (n == W) break;
        end
        chk("t6_last_shift_reached", n, W);
        #2;
        v1[2] = 1'b1;
        d1[2] = 4'h9;
        wc   = 0;
        bc   = 0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (r1[2]) begin
                seen = 1'b1;
                break;
            end
            wc++;
            if (bsy[2]) bc++;
        end
        chk("t6_ready_seen", {31'd0, seen}, 32'd1);
        chk("t6_wait_cycles", wc, 3);
        chk("t6_busy_cycles", bc, 3);
        @(posedge clk);
        #2;
        v1[2] = 1'b0;
        run_frame(2, bits, nb, qv, g, dc);
        chk("t6_q", {28'd0, qv}, 32'h9);
        chk("t6_gid", {31'd0, g}, 32'd1);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
        $finish;
    end

endmodule
